// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit core pipeline: opcode and I-type sub-op
// encodings, instruction field positions, the memory/write-back state
// encoding and small field-extraction helpers.
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Major opcode, instr[7:6]
   typedef enum logic [1:0] {
      OP_R    = 2'b00,
      OP_I    = 2'b01,
      OP_J    = 2'b10,
      OP_HALT = 2'b11
   } opcode_e;

   // I-type sub-operation, instr[5:4]
   typedef enum logic [1:0] {
      I_ADDI = 2'b00,
      I_LD   = 2'b01,
      I_ST   = 2'b10,
      I_CMP  = 2'b11
   } isub_e;

   // Memory-access / write-back stage states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      MEM    = 2'b01,
      WB     = 2'b10,
      HALTED = 2'b11
   } mwb_state_e;

   // Instruction field slices
   localparam int INSTR_W = 8;
   localparam int OP_HI   = 7;
   localparam int OP_LO   = 6;
   localparam int SUB_HI  = 5;
   localparam int SUB_LO  = 4;
   localparam int RT_HI   = 3;
   localparam int RT_LO   = 2;

   function automatic opcode_e get_op(input logic [INSTR_W-1:0] instr);
      return opcode_e'(instr[OP_HI:OP_LO]);
   endfunction

   function automatic isub_e get_sub(input logic [INSTR_W-1:0] instr);
      return isub_e'(instr[SUB_HI:SUB_LO]);
   endfunction

   function automatic logic [1:0] get_rt(input logic [INSTR_W-1:0] instr);
      return instr[RT_HI:RT_LO];
   endfunction

endpackage

// File: rtl/mem_writeback.sv
// -----------------------------------------------------------------------------
// mem_writeback
// Memory-access / write-back stage of the 8-bit core. Accepts one executed
// instruction per ex_valid/ex_ready handshake, performs LD/ST against a
// variable-latency data memory with a bounded wait, writes R/ADDI/LD/CMP
// results to the register file, counts retirements and latches HALT.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ex_valid/ex_ready             handshake from the execute stage
//   ex_instr/ex_result/ex_wdata   instruction, ALU result / address, store data
//   dmem_req/we/addr/wdata        data-memory request, held until dmem_ack
//   dmem_ack/dmem_rdata           memory completion and load data
//   rf_we/rf_waddr/rf_wdata       one-cycle register-file write port
//   halted                        sticky, HALT retired
//   mem_err                       sticky, memory request timed out
//   retire_cnt                    retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module mem_writeback
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [7:0]        ex_instr,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] ex_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              rf_we,
   output logic [1:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              halted,
   output logic              mem_err,
   output logic [CNT_W-1:0]  retire_cnt
);

   mwb_state_e        r_state;
   logic [7:0]        r_wait;
   logic [DATA_W-1:0] r_data;     // ALU result / effective address, then load data
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        r_rt;
   logic              r_is_st;
   logic              r_mem_err;
   logic [CNT_W-1:0]  r_retire;

   mwb_state_e        w_next_state;
   opcode_e           w_op;
   isub_e             w_sub;
   logic              w_transfer;
   logic              w_timeout;
   logic              w_retire_inc;
   logic              w_set_err;
   logic              w_capture;
   logic              w_load_rdata;
   logic              w_in_mem;
   logic              w_in_wb;

   assign w_op       = get_op(ex_instr);
   assign w_sub      = get_sub(ex_instr);
   assign w_transfer = ex_valid && (r_state == IDLE);
   // Last permitted wait cycle: with the counter starting at 0, req stays up
   // for exactly MEM_TIMEOUT cycles.
   assign w_timeout  = (r_wait == 8'(MEM_TIMEOUT - 1));
   assign w_in_mem   = (r_state == MEM);
   assign w_in_wb    = (r_state == WB);

   // Next-state, retire and capture decode
   always_comb begin
      w_next_state = r_state;
      w_retire_inc = 1'b0;
      w_set_err    = 1'b0;
      w_capture    = 1'b0;
      w_load_rdata = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_transfer) begin
               w_capture = 1'b1;
               case (w_op)
                  OP_R: begin
                     w_next_state = WB;
                  end
                  OP_I: begin
                     if ((w_sub == I_LD) || (w_sub == I_ST)) begin
                        w_next_state = MEM;
                     end else begin
                        w_next_state = WB;
                     end
                  end
                  OP_J: begin
                     w_next_state = IDLE;
                     w_retire_inc = 1'b1;
                  end
                  OP_HALT: begin
                     w_next_state = HALTED;
                     w_retire_inc = 1'b1;
                  end
                  default: begin
                     w_next_state = IDLE;
                  end
               endcase
            end else begin
               w_next_state = IDLE;
            end
         end
         MEM: begin
            // An ack in the final wait cycle takes priority over the timeout
            if (dmem_ack) begin
               if (r_is_st) begin
                  w_next_state = IDLE;
                  w_retire_inc = 1'b1;
               end else begin
                  w_next_state = WB;
                  w_load_rdata = 1'b1;
               end
            end else if (w_timeout) begin
               w_next_state = IDLE;
               w_set_err    = 1'b1;
            end else begin
               w_next_state = MEM;
            end
         end
         WB: begin
            w_next_state = IDLE;
            w_retire_inc = 1'b1;
         end
         HALTED: begin
            w_next_state = HALTED;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, capture registers, wait counter, sticky error and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_wait    <= 8'd0;
         r_data    <= '0;
         r_wdata   <= '0;
         r_rt      <= 2'b00;
         r_is_st   <= 1'b0;
         r_mem_err <= 1'b0;
         r_retire  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) begin
            r_data  <= ex_result;
            r_wdata <= ex_wdata;
            r_rt    <= get_rt(ex_instr);
            r_is_st <= (w_op == OP_I) && (w_sub == I_ST);
         end else if (w_load_rdata) begin
            r_data <= dmem_rdata;
         end else begin
            r_data <= r_data;
         end
         if (w_in_mem) begin
            r_wait <= r_wait + 8'd1;
         end else begin
            r_wait <= 8'd0;
         end
         if (w_set_err) begin
            r_mem_err <= 1'b1;
         end else begin
            r_mem_err <= r_mem_err;
         end
         if (w_retire_inc) begin
            r_retire <= r_retire + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_retire <= r_retire;
         end
      end
   end

   // Outputs decode straight from registered state; memory and register-file
   // buses are zero outside the cycles in which they are meaningful.
   assign ex_ready   = (r_state == IDLE);
   assign dmem_req   = w_in_mem;
   assign dmem_we    = w_in_mem && r_is_st;
   assign dmem_addr  = w_in_mem ? r_data  : '0;
   assign dmem_wdata = w_in_mem ? r_wdata : '0;
   assign rf_we      = w_in_wb;
   assign rf_waddr   = w_in_wb ? r_rt    : 2'b00;
   assign rf_wdata   = w_in_wb ? r_data  : '0;
   assign halted     = (r_state == HALTED);
   assign mem_err    = r_mem_err;
   assign retire_cnt = r_retire;

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

   logic       clk;
   logic       rst;
   logic       ex_valid;
   logic       ex_ready;
   logic [7:0] ex_instr;
   logic [7:0] ex_result;
   logic [7:0] ex_wdata;
   logic       dmem_req;
   logic       dmem_we;
   logic [7:0] dmem_addr;
   logic [7:0] dmem_wdata;
   logic       dmem_ack;
   logic [7:0] dmem_rdata;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic       halted;
   logic       mem_err;
   logic [7:0] retire_cnt;

   int n_pass;
   int n_total;
   logic [7:0] exp_retire;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] res;
      logic       exp_we;
      logic [1:0] exp_waddr;
      logic [7:0] exp_wdata;
   } vec_t;

   vec_t vecs[6];

   mem_writeback #(.DATA_W(8), .MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_instr   (ex_instr),
      .ex_result  (ex_result),
      .ex_wdata   (ex_wdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .halted     (halted),
      .mem_err    (mem_err),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   // Present one instruction for one edge; returns at the negedge of the
   // cycle after the transfer edge.
   task automatic issue(input logic [7:0] instr, input logic [7:0] res, input logic [7:0] wd);
      ex_valid  = 1'b1;
      ex_instr  = instr;
      ex_result = res;
      ex_wdata  = wd;
      @(negedge clk);
      ex_valid  = 1'b0;
      ex_instr  = 8'h00;
      ex_result = 8'h00;
      ex_wdata  = 8'h00;
   endtask

   initial begin
      int n_req;
      n_pass     = 0;
      n_total    = 0;
      exp_retire = 8'd0;
      rst        = 1'b1;
      ex_valid   = 1'b0;
      ex_instr   = 8'h00;
      ex_result  = 8'h00;
      ex_wdata   = 8'h00;
      dmem_ack   = 1'b0;
      dmem_rdata = 8'h00;

      //              instr   result  we    waddr  wdata
      vecs[0] = '{8'h0C, 8'h07, 1'b1, 2'd3, 8'h07};  // R, rt=3
      vecs[1] = '{8'h40, 8'hFF, 1'b1, 2'd0, 8'hFF};  // ADDI, rt=0
      vecs[2] = '{8'h74, 8'h80, 1'b1, 2'd1, 8'h80};  // CMP, rt=1
      vecs[3] = '{8'h84, 8'h55, 1'b0, 2'd0, 8'h00};  // J, no write
      vecs[4] = '{8'h38, 8'h00, 1'b1, 2'd2, 8'h00};  // R, rt=2, zero data
      vecs[5] = '{8'h2B, 8'h5A, 1'b1, 2'd2, 8'h5A};  // R, rt=2, low bits ignored

      @(negedge clk);
      @(negedge clk);
      chk("reset_ex_ready", ex_ready, 1);
      chk("reset_dmem_req", dmem_req, 0);
      chk("reset_rf_we", rf_we, 0);
      chk("reset_halted", halted, 0);
      chk("reset_mem_err", mem_err, 0);
      chk("reset_retire", retire_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single-instruction table
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].instr, vecs[i].res, 8'h00);
         exp_retire = exp_retire + 8'd1;
         chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
         chk($sformatf("vec%0d_ex_ready", i), ex_ready, !vecs[i].exp_we);
         chk($sformatf("vec%0d_dmem_req", i), dmem_req, 0);
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].exp_waddr);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
         end else begin
            chk($sformatf("vec%0d_retire_early", i), retire_cnt, exp_retire);
         end
         @(negedge clk);
         chk($sformatf("vec%0d_rf_we_off", i), rf_we, 0);
         chk($sformatf("vec%0d_retire", i), retire_cnt, exp_retire);
      end

      // LD with ack in the third request cycle
      issue(8'h58, 8'h20, 8'h00);
      chk("ld_req_c1", dmem_req, 1);
      chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, 8'h20);
      chk("ld_ready_low", ex_ready, 0);
      @(negedge clk);
      chk("ld_req_c2", dmem_req, 1);
      @(negedge clk);
      chk("ld_req_c3", dmem_req, 1);
      chk("ld_addr_stable", dmem_addr, 8'h20);
      dmem_ack   = 1'b1;
      dmem_rdata = 8'hA5;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 8'h00;
      exp_retire = exp_retire + 8'd1;
      chk("ld_req_drop", dmem_req, 0);
      chk("ld_rf_we", rf_we, 1);
      chk("ld_waddr", rf_waddr, 2'd2);
      chk("ld_wdata", rf_wdata, 8'hA5);
      @(negedge clk);
      chk("ld_retire", retire_cnt, exp_retire);

      // Stray ack while idle changes nothing
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("stray_ack_req", dmem_req, 0);
      chk("stray_ack_rf_we", rf_we, 0);
      chk("stray_ack_retire", retire_cnt, exp_retire);
      chk("stray_ack_ready", ex_ready, 1);

      // ST with immediate ack
      issue(8'h64, 8'h10, 8'h3C);
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 8'h10);
      chk("st_wdata", dmem_wdata, 8'h3C);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      exp_retire = exp_retire + 8'd1;
      chk("st_req_drop", dmem_req, 0);
      chk("st_no_rf_we", rf_we, 0);
      chk("st_ready", ex_ready, 1);
      chk("st_retire", retire_cnt, exp_retire);

      // LD acked in the last permitted cycle: ack wins over timeout
      issue(8'h58, 8'h40, 8'h00);
      for (int k = 0; k < 14; k++) @(negedge clk);
      chk("ld15_req_c15", dmem_req, 1);
      dmem_ack   = 1'b1;
      dmem_rdata = 8'h9C;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 8'h00;
      exp_retire = exp_retire + 8'd1;
      chk("ld15_rf_we", rf_we, 1);
      chk("ld15_wdata", rf_wdata, 8'h9C);
      chk("ld15_no_err", mem_err, 0);
      @(negedge clk);
      chk("ld15_retire", retire_cnt, exp_retire);

      // LD with no ack: timeout after 15 request cycles
      issue(8'h58, 8'h33, 8'h00);
      n_req = 0;
      for (int k = 0; k < 40; k++) begin
         if (!dmem_req) break;
         n_req = n_req + 1;
         @(negedge clk);
      end
      chk("to_req_cycles", n_req, 15);
      chk("to_mem_err", mem_err, 1);
      chk("to_ready", ex_ready, 1);
      chk("to_no_rf_we", rf_we, 0);
      chk("to_retire", retire_cnt, exp_retire);

      // Reset asserted mid-MEM
      issue(8'h64, 8'h77, 8'h11);
      chk("rstm_req_before", dmem_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstm_req", dmem_req, 0);
      chk("rstm_we", dmem_we, 0);
      chk("rstm_addr", dmem_addr, 0);
      chk("rstm_ready", ex_ready, 1);
      chk("rstm_mem_err", mem_err, 0);
      chk("rstm_retire", retire_cnt, 0);
      chk("rstm_halted", halted, 0);
      chk("rstm_rf_we", rf_we, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_retire = 8'd0;
      @(negedge clk);

      // 256 ALU retirements wrap the counter
      for (int i = 0; i < 256; i++) begin
         issue(8'h0C, 8'(i), 8'h00);
         @(negedge clk);
         if (i == 254) chk("wrap_255", retire_cnt, 8'd255);
      end
      chk("wrap_0", retire_cnt, 0);

      // HALT, then further requests are refused
      issue(8'hC0, 8'h00, 8'h00);
      chk("halt_halted", halted, 1);
      chk("halt_ready", ex_ready, 0);
      chk("halt_retire", retire_cnt, 1);
      ex_valid = 1'b1;
      ex_instr = 8'h0C;
      for (int k = 0; k < 4; k++) @(negedge clk);
      ex_valid = 1'b0;
      ex_instr = 8'h00;
      chk("halt_sticky", halted, 1);
      chk("halt_ready_low", ex_ready, 0);
      chk("halt_no_rf_we", rf_we, 0);
      chk("halt_retire_hold", retire_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
